// File: rtl/int_to_pontos_flutuantes_if.sv
// Handshake and data bundle between an integer producer and the float encoder.
// The master drives start/int_in, the encoder (slave) returns busy/done/result.
interface int_to_pontos_flutuantes_if;
  logic        start;
  logic [31:0] int_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  modport master (
    output start, int_in,
    input  busy, done, data_out, status_out
  );

  modport slave (
    input  start, int_in,
    output busy, done, data_out, status_out
  );
endinterface

// File: rtl/int_to_pontos_flutuantes.sv
// Signed 32-bit integer to custom float (1/6/25, bias 31) with bit-serial normalisation.
// Latency: 1 cycle for zero, L+3 cycles otherwise (L = leading zeros of |X|); start ignored while busy.
module int_to_pontos_flutuantes #(
  parameter int BIAS = 31
) (
  input  logic                         clock_100kHz,
  input  logic                         reset,
  int_to_pontos_flutuantes_if.slave    bus
);

  typedef enum logic [2:0] {IDLE, LOAD, NORM, ROUND, DONE} state_t;

  // Exponent when the leading one already sits in bit 31 (no shifts needed).
  localparam logic [5:0] EXP_TOP = 6'(BIAS + 31);

  state_t      state, state_nxt;
  logic [31:0] operand;
  logic [31:0] mag;
  logic        sign;
  logic [4:0]  cnt;
  logic [31:0] data_q;
  logic [3:0]  status_q;

  logic [31:0] mag_abs;
  logic [24:0] m_trunc;
  logic        guard, sticky, round_up;
  logic [25:0] m_sum;
  logic [5:0]  e_base, e_fin;

  // 0x80000000 negates to itself, which is exactly the magnitude wanted.
  assign mag_abs  = operand[31] ? (~operand + 32'd1) : operand;

  assign m_trunc  = mag[30:6];
  assign guard    = mag[5];
  assign sticky   = |mag[4:0];
  assign round_up = guard & (sticky | m_trunc[0]);
  assign m_sum    = {1'b0, m_trunc} + {25'd0, round_up};
  assign e_base   = EXP_TOP - {1'b0, cnt};
  // A mantissa carry leaves m_sum[24:0] at zero and bumps the exponent.
  assign e_fin    = e_base + {5'd0, m_sum[25]};

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    state_nxt = (mag_abs == 32'd0) ? DONE : NORM;
      NORM:    if (mag[31]) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      operand  <= '0;
      mag      <= '0;
      sign     <= 1'b0;
      cnt      <= '0;
      data_q   <= '0;
      status_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) operand <= bus.int_in;
        LOAD: begin
          sign <= operand[31];
          mag  <= mag_abs;
          cnt  <= '0;
          if (mag_abs == 32'd0) begin
            data_q   <= '0;
            status_q <= 4'b1000;
          end
        end
        NORM: if (!mag[31]) begin
          mag <= mag << 1;
          cnt <= cnt + 5'd1;
        end
        ROUND: begin
          data_q   <= {sign, e_fin, m_sum[24:0]};
          status_q <= {1'b0, guard | sticky, sign, round_up};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.data_out   = data_q;
  assign bus.status_out = status_q;

endmodule

// File: tb/tb_int_to_pontos_flutuantes.sv
// Directed bench for the integer-to-float encoder: values, status, latency and handshake.
module tb_int_to_pontos_flutuantes;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] r_data;
  logic [3:0]  r_status;
  int          r_lat;

  int_to_pontos_flutuantes_if bus();

  int_to_pontos_flutuantes dut (
    .clock_100kHz (clk),
    .reset        (rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Starts one conversion from IDLE, waits for done, returns with the encoder back in IDLE.
  task automatic run_conv(input logic [31:0] val);
    bus.start  = 1'b1;
    bus.int_in = val;
    @(posedge clk); #1;
    bus.start = 1'b0;
    r_lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        r_lat = n;
        break;
      end
    end
    r_data   = bus.data_out;
    r_status = bus.status_out;
    if (r_lat < 0) begin
      checks++; errors++;
      $display("FAIL timeout val=%h no done within 60 cycles", val);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int dn;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.int_in = '0;
    #12;
    checks++;
    if ({bus.busy, bus.done, bus.data_out, bus.status_out} !== 38'd0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b data=%h status=%b want all 0",
               bus.busy, bus.done, bus.data_out, bus.status_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_conv(32'd3);
    // abort a long conversion mid-normalisation
    bus.start = 1'b1;
    bus.int_in = 32'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.data_out, bus.status_out} !== 38'd0) begin
      errors++;
      $display("FAIL reset_mid_norm got busy=%b done=%b data=%h status=%b want all 0",
               bus.busy, bus.done, bus.data_out, bus.status_out);
    end
    dn = 0;
    repeat (3) begin @(posedge clk); #1; if (bus.done === 1'b1) dn++; end
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (bus.done === 1'b1) dn++; end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL reset_no_done got %0d done pulses want 0", dn);
    end
    run_conv(32'd2);
    checks++;
    if (r_data !== 32'h4000_0000) begin
      errors++;
      $display("FAIL reset_recover got %h want 40000000", r_data);
    end
  endtask

  task automatic test_values();
    logic [31:0] vin  [9];
    logic [31:0] vexp [9];
    logic [3:0]  sexp [9];
    int          lexp [9];
    vin[0]=32'd1;          vexp[0]=32'h3E00_0000; sexp[0]=4'b0000; lexp[0]=34;
    vin[1]=32'd2;          vexp[1]=32'h4000_0000; sexp[1]=4'b0000; lexp[1]=33;
    vin[2]=32'd3;          vexp[2]=32'h4100_0000; sexp[2]=4'b0000; lexp[2]=33;
    vin[3]=32'hFFFF_FFFF;  vexp[3]=32'hBE00_0000; sexp[3]=4'b0010; lexp[3]=34;
    vin[4]=32'd0;          vexp[4]=32'h0000_0000; sexp[4]=4'b1000; lexp[4]=1;
    vin[5]=32'h8000_0000;  vexp[5]=32'hFC00_0000; sexp[5]=4'b0010; lexp[5]=3;
    vin[6]=32'h7FFF_FFFF;  vexp[6]=32'h7C00_0000; sexp[6]=4'b0101; lexp[6]=4;
    vin[7]=32'h0400_0001;  vexp[7]=32'h7200_0000; sexp[7]=4'b0100; lexp[7]=8;
    vin[8]=32'h0400_0003;  vexp[8]=32'h7200_0002; sexp[8]=4'b0101; lexp[8]=8;
    for (int i = 0; i < 9; i++) begin
      run_conv(vin[i]);
      checks++;
      if (r_data !== vexp[i]) begin
        errors++;
        $display("FAIL data in=%h got %h want %h", vin[i], r_data, vexp[i]);
      end
      checks++;
      if (r_status !== sexp[i]) begin
        errors++;
        $display("FAIL status in=%h got %b want %b", vin[i], r_status, sexp[i]);
      end
      checks++;
      if (r_lat !== lexp[i]) begin
        errors++;
        $display("FAIL latency in=%h got %0d want %0d", vin[i], r_lat, lexp[i]);
      end
    end
    // result must hold after done drops
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.data_out !== 32'h7200_0002 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL hold got data=%h busy=%b want 72000002 busy=0", bus.data_out, bus.busy);
    end
  endtask

  task automatic test_ignore_start();
    int dn;
    dn = 0;
    bus.start = 1'b1;
    bus.int_in = 32'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.int_in = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (45) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dn++;
    end
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL ignore_start got %0d done pulses want 1", dn);
    end
    checks++;
    if (bus.data_out !== 32'h3E00_0000) begin
      errors++;
      $display("FAIL ignore_start_data got %h want 3E000000", bus.data_out);
    end
  endtask

  task automatic test_back_to_back();
    int dn, last, idle_cnt, bad_gap, bad_idle, bad_data;
    dn = 0; last = -1; idle_cnt = 0; bad_gap = 0; bad_idle = 0; bad_data = 0;
    bus.start = 1'b1;
    bus.int_in = 32'h8000_0000;
    for (int c = 0; c < 60 && dn < 3; c++) begin
      @(posedge clk); #1;
      if (bus.busy === 1'b0) idle_cnt++;
      if (bus.done === 1'b1) begin
        if (bus.data_out !== 32'hFC00_0000) bad_data++;
        if (last >= 0 && c - last != 5) bad_gap++;
        if (last >= 0 && idle_cnt != 1) bad_idle++;
        last = c;
        idle_cnt = 0;
        dn++;
        if (dn == 3) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dn !== 3) begin
      errors++;
      $display("FAIL b2b_count got %0d done pulses want 3", dn);
    end
    checks++;
    if (bad_gap !== 0 || bad_idle !== 0) begin
      errors++;
      $display("FAIL b2b_spacing got %0d bad gaps %0d bad idle windows want 0/0", bad_gap, bad_idle);
    end
    checks++;
    if (bad_data !== 0) begin
      errors++;
      $display("FAIL b2b_data got %0d wrong results want 0", bad_data);
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_ignore_start();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
